// File: rtl/dct_mac.sv
// DCT multiply-accumulate: radix-4 Booth product summed over NTAP taps, result after E3 of the last tap.
// Input stalls (in_ready low) from the last tap until the result is taken; DCT_MAC_SAT_EN clamps the output.
module dct_mac #(
  parameter int AW   = 16,
  parameter int BW   = 8,
  parameter int NTAP = 20,
  parameter int OW   = 23
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] in1,
  input  logic [BW-1:0] in2,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          clr,
  output logic [OW-1:0] out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sat
);

  localparam int PW   = AW + BW;
  localparam int NPP  = BW / 2;
  localparam int ACCW = PW + $clog2(NTAP);
  localparam int CW   = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam logic [CW-1:0] LAST_TAP = CW'(NTAP - 1);

  // Folds the sign extension of every partial product into one constant row.
  function automatic logic [PW-1:0] f_sext_k();
    logic [PW-1:0] k;
    k = '0;
    for (int i = 0; i < NPP; i++) k = k - (PW'(1) << (AW + 2 * i));
    return k;
  endfunction

  localparam logic [PW-1:0] SEXT_K = f_sext_k();

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HOLD} state_t;

  logic [BW:0]   w_b;
  logic [AW:0]   w_a1;
  logic [AW:0]   w_a2;
  logic [PW-1:0] w_row [NPP+2];
  logic [PW-1:0] w_cs_s;
  logic [PW-1:0] w_cs_c;
  logic          w_accept;
  logic          w_last_acc;
  logic [OW-1:0] w_red;
  logic          w_sat;

  state_t                r_state;
  logic [CW-1:0]         r_tap;
  logic [PW-1:0]         r_cs_s;
  logic [PW-1:0]         r_cs_c;
  logic                  r_v0;
  logic                  r_l0;
  logic signed [PW-1:0]  r_prod;
  logic                  r_v1;
  logic                  r_l1;
  logic                  r_l2;
  logic signed [ACCW-1:0] r_acc;

  assign w_b        = {in2, 1'b0};
  assign w_a1       = {in1[AW-1], in1};
  assign w_a2       = {in1, 1'b0};
  assign w_accept   = in_valid && in_ready;
  assign w_last_acc = w_accept && (r_tap == LAST_TAP);

  always_comb begin : p_booth
    logic [2:0]    trip;
    logic [AW:0]   mag;
    logic [PW-1:0] negs;
    trip = '0;
    mag  = '0;
    negs = '0;
    for (int i = 0; i < NPP; i++) begin
      trip = w_b[2*i +: 3];
      case (trip)
        3'b001, 3'b010, 3'b101, 3'b110: mag = w_a1;
        3'b011, 3'b100:                 mag = w_a2;
        default:                        mag = '0;
      endcase
      if (trip[2]) mag = ~mag;
      mag[AW]  = ~mag[AW];
      w_row[i] = PW'(mag) << (2 * i);
      negs[2*i] = trip[2];
    end
    w_row[NPP]   = negs;
    w_row[NPP+1] = SEXT_K;
  end

  always_comb begin : p_csa
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    logic [PW-1:0] t;
    s = w_row[0];
    c = w_row[1];
    t = '0;
    for (int i = 2; i < NPP + 2; i++) begin
      t = s ^ c ^ w_row[i];
      c = ((s & c) | (s & w_row[i]) | (c & w_row[i])) << 1;
      s = t;
    end
    w_cs_s = s;
    w_cs_c = c;
  end

`ifdef DCT_MAC_SAT_EN
  localparam int MW = (ACCW > OW) ? ACCW : OW;
  localparam logic signed [MW-1:0] OMAX = {{(MW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [MW-1:0] OMIN = ~OMAX;
  logic signed [MW-1:0] w_accx;
  assign w_accx = MW'(r_acc);
  always_comb begin
    w_red = w_accx[OW-1:0];
    w_sat = 1'b0;
    if (w_accx > OMAX) begin
      w_red = OMAX[OW-1:0];
      w_sat = 1'b1;
    end else if (w_accx < OMIN) begin
      w_red = OMIN[OW-1:0];
      w_sat = 1'b1;
    end
  end
`else
  assign w_red = OW'(r_acc);
  assign w_sat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_tap     <= '0;
      r_cs_s    <= '0;
      r_cs_c    <= '0;
      r_v0      <= 1'b0;
      r_l0      <= 1'b0;
      r_prod    <= '0;
      r_v1      <= 1'b0;
      r_l1      <= 1'b0;
      r_l2      <= 1'b0;
      r_acc     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
      in_ready  <= 1'b0;
    end else if (clr) begin
      r_state   <= S_IDLE;
      r_tap     <= '0;
      r_v0      <= 1'b0;
      r_l0      <= 1'b0;
      r_v1      <= 1'b0;
      r_l1      <= 1'b0;
      r_l2      <= 1'b0;
      r_acc     <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      r_v0 <= w_accept;
      r_l0 <= w_last_acc;
      if (w_accept) begin
        r_cs_s <= w_cs_s;
        r_cs_c <= w_cs_c;
        r_tap  <= w_last_acc ? '0 : r_tap + CW'(1);
      end
      r_v1 <= r_v0;
      r_l1 <= r_l0;
      if (r_v0) r_prod <= r_cs_s + r_cs_c;
      r_l2 <= r_l1;
      // The final sum is captured into out on the same edge that clears it.
      if (r_l2) r_acc <= '0;
      else if (r_v1) r_acc <= r_acc + ACCW'(r_prod);
      case (r_state)
        S_IDLE, S_RUN: begin
          in_ready <= !w_last_acc;
          if (w_last_acc) r_state <= S_DRAIN;
          else if (w_accept) r_state <= S_RUN;
        end
        S_DRAIN: begin
          if (r_l2) begin
            out       <= w_red;
            sat       <= w_sat;
            out_valid <= 1'b1;
            r_state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dct_mac.sv
// Bench for dct_mac: NTAP=1 and NTAP=4 instances checked against a plain-arithmetic sum-of-products model.
module tb_dct_mac;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clr, in_valid, out_ready;
  logic [15:0] in1;
  logic [7:0]  in2;
  logic        rdy1, ov1, sat1, rdy4, ov4, sat4;
  logic [22:0] out1, out4;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] s_a[$];
  logic [7:0]  s_b[$];

  dct_mac #(.AW(16), .BW(8), .NTAP(1), .OW(23)) u1 (
    .clk(clk), .reset(reset), .in1(in1), .in2(in2), .in_valid(in_valid),
    .in_ready(rdy1), .clr(clr), .out(out1), .out_valid(ov1),
    .out_ready(out_ready), .sat(sat1));

  dct_mac #(.AW(16), .BW(8), .NTAP(4), .OW(23)) u4 (
    .clk(clk), .reset(reset), .in1(in1), .in2(in2), .in_valid(in_valid),
    .in_ready(rdy4), .clr(clr), .out(out4), .out_valid(ov4),
    .out_ready(out_ready), .sat(sat4));

  function automatic logic sel_rdy(input bit sel4);
    return sel4 ? rdy4 : rdy1;
  endfunction
  function automatic logic sel_ov(input bit sel4);
    return sel4 ? ov4 : ov1;
  endfunction
  function automatic logic sel_sat(input bit sel4);
    return sel4 ? sat4 : sat1;
  endfunction
  function automatic logic [22:0] sel_out(input bit sel4);
    return sel4 ? out4 : out1;
  endfunction

  // Reference: exact sum of signed products, then reduced to 23 bits.
  function automatic longint model_sum();
    longint acc;
    acc = 0;
    foreach (s_a[i]) acc += longint'($signed(s_a[i])) * longint'($signed(s_b[i]));
    return acc;
  endfunction

  function automatic logic [22:0] model_out(input longint acc);
    logic [63:0] t;
    t = acc;
`ifdef DCT_MAC_SAT_EN
    if (acc > 64'sd4194303) return 23'h3FFFFF;
    if (acc < -64'sd4194304) return 23'h400000;
`endif
    return t[22:0];
  endfunction

  function automatic logic model_sat(input longint acc);
`ifdef DCT_MAC_SAT_EN
    return (acc > 64'sd4194303) || (acc < -64'sd4194304);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] rand_a();
    case ($urandom_range(3))
      0: rand_a = 16'h8000;
      1: rand_a = 16'h7FFF;
      default: rand_a = 16'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] rand_b();
    case ($urandom_range(3))
      0: rand_b = 8'h80;
      1: rand_b = 8'h7F;
      default: rand_b = 8'($urandom);
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Presents the queued samples; returns at the negedge after the last accept.
  task automatic feed(input bit sel4, input bit gaps);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < s_a.size() && guard < 400) begin
      if (gaps && $urandom_range(3) == 0) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in1 = s_a[i];
        in2 = s_b[i];
        if (sel_rdy(sel4)) i++;
      end
      guard++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_chk++;
    if (i != s_a.size()) $display("FAIL feed_timeout: accepted %0d of %0d samples", i, s_a.size());
    else n_pass++;
  endtask

  task automatic wait_result(input bit sel4, input logic [22:0] eo, input logic es,
                             input int hold, input string nm);
    int lat;
    n_chk++;
    if (sel_rdy(sel4) !== 1'b0) $display("FAIL %s in_ready_after_last: got %b want 0", nm, sel_rdy(sel4));
    else n_pass++;
    lat = 0;
    while (sel_ov(sel4) !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_chk++;
    if (lat != 3) $display("FAIL %s latency: got %0d cycles want 3", nm, lat);
    else n_pass++;
    n_chk++;
    if (sel_out(sel4) !== eo || sel_sat(sel4) !== es)
      $display("FAIL %s result: got out=%h sat=%b want out=%h sat=%b", nm, sel_out(sel4), sel_sat(sel4), eo, es);
    else n_pass++;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      n_chk++;
      if (sel_ov(sel4) !== 1'b1 || sel_out(sel4) !== eo || sel_sat(sel4) !== es || sel_rdy(sel4) !== 1'b0)
        $display("FAIL %s hold%0d: got ov=%b out=%h sat=%b rdy=%b want ov=1 out=%h sat=%b rdy=0",
                 nm, k, sel_ov(sel4), sel_out(sel4), sel_sat(sel4), sel_rdy(sel4), eo, es);
      else n_pass++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_chk++;
    if (sel_ov(sel4) !== 1'b0 || sel_rdy(sel4) !== 1'b1)
      $display("FAIL %s handshake: got ov=%b rdy=%b want ov=0 rdy=1", nm, sel_ov(sel4), sel_rdy(sel4));
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if ({rdy1, ov1, sat1, out1} !== 26'b0) $display("FAIL reset_u1: got rdy=%b ov=%b sat=%b out=%h want all 0", rdy1, ov1, sat1, out1);
    else n_pass++;
    n_chk++;
    if ({rdy4, ov4, sat4, out4} !== 26'b0) $display("FAIL reset_u4: got rdy=%b ov=%b sat=%b out=%h want all 0", rdy4, ov4, sat4, out4);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (rdy1 !== 1'b1 || rdy4 !== 1'b1) $display("FAIL reset_release_rdy: got %b%b want 11", rdy1, rdy4);
    else n_pass++;
  endtask

  task automatic test_ntap1();
    longint acc;
    do_reset();
    s_a = {16'h7FFF}; s_b = {8'h7F};
    feed(1'b0, 1'b0);
    wait_result(1'b0, 23'h3F7F81, 1'b0, 0, "max_pos");
    s_a = {16'h8000}; s_b = {8'h80};
    feed(1'b0, 1'b0);
`ifdef DCT_MAC_SAT_EN
    wait_result(1'b0, 23'h3FFFFF, 1'b1, 1, "max_neg");
`else
    wait_result(1'b0, 23'h400000, 1'b0, 1, "max_neg");
`endif
    for (int f = 0; f < 6; f++) begin
      s_a = {rand_a()}; s_b = {rand_b()};
      acc = model_sum();
      feed(1'b0, 1'b1);
      wait_result(1'b0, model_out(acc), model_sat(acc), $urandom_range(2), "rnd_ntap1");
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    s_a = {16'd100, 16'd200, 16'hFED4, 16'd400};
    s_b = {8'd3, 8'd3, 8'd3, 8'd3};
    feed(1'b1, 1'b0);
    wait_result(1'b1, 23'h0004B0, 1'b0, 5, "b2b_hold");
  endtask

  task automatic test_clr();
    do_reset();
    s_a = {16'd7, 16'd9}; s_b = {8'd2, 8'd2};
    feed(1'b1, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in1 = 16'd50; in2 = 8'd5;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    n_chk++;
    if (ov4 !== 1'b0 || rdy4 !== 1'b1) $display("FAIL clr_state: got ov=%b rdy=%b want ov=0 rdy=1", ov4, rdy4);
    else n_pass++;
    s_a = {16'd1, 16'd2, 16'd3, 16'd4}; s_b = {8'd1, 8'd1, 8'd1, 8'd1};
    feed(1'b1, 1'b0);
    wait_result(1'b1, 23'h00000A, 1'b0, 0, "after_clr");
  endtask

  task automatic test_reset_mid();
    s_a = {16'd11, 16'd13}; s_b = {8'd3, 8'd3};
    feed(1'b1, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({rdy4, ov4, sat4, out4} !== 26'b0) $display("FAIL mid_reset: got rdy=%b ov=%b sat=%b out=%h want all 0", rdy4, ov4, sat4, out4);
    else n_pass++;
    reset = 1'b1;
    s_a = {16'd5, 16'd5, 16'd5, 16'd5}; s_b = {8'hFE, 8'hFE, 8'hFE, 8'hFE};
    feed(1'b1, 1'b0);
    wait_result(1'b1, 23'h7FFFD8, 1'b0, 1, "post_reset");
  endtask

  task automatic test_random_frames();
    longint acc;
    do_reset();
    for (int f = 0; f < 8; f++) begin
      s_a.delete(); s_b.delete();
      for (int t = 0; t < 4; t++) begin
        s_a.push_back(rand_a());
        s_b.push_back(rand_b());
      end
      acc = model_sum();
      feed(1'b1, 1'b1);
      wait_result(1'b1, model_out(acc), model_sat(acc), $urandom_range(3), "rnd_ntap4");
    end
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in1 = '0; in2 = '0;
    test_reset();
    test_ntap1();
    test_back_to_back();
    test_clr();
    test_reset_mid();
    test_random_frames();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
